stream_pack_ctrl: RTL
=====================

// Module: stream_pack_ctrl
// PURPOSE
//   Multi-cycle sequencer for the streaming-reorder datapath. Moves one k-bit slice per clock.
//   Left stream ({<<k{x}}) reverses slice order. Right stream ({>>k{x}}) keeps slice order.
//   Sits between a valid/ready producer and a valid/ready consumer. Reorders one WIDTH-bit word at a time.
// PARAMETERS
//   WIDTH      24  payload width in bits (>= 2)
//   MAX_SLICE  8   largest legal slice size in bits (1..WIDTH)
// PORTS
//   clk        in   1                   rising-edge clock
//   rst_n      in   1                   synchronous reset, active low
//   in_valid   in   1                   producer has a word
//   in_ready   out  1                   block accepts a word
//   in_data    in   WIDTH               word to reorder
//   cfg_slice  in   $clog2(MAX_SLICE+1) slice size k; sampled on accept only
//   cfg_left   in   1                   1 = left stream (reverse slices), 0 = right stream
//   out_valid  out  1                   result available
//   out_ready  in   1                   consumer takes result
//   out_data   out  WIDTH               reordered word
//   busy       out  1                   state != IDLE
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-low: rst_n sampled low at a clk edge resets the block.
//   - Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0; slice pointer and count = 0.
//   - Slice-size rules: k=0 is treated as 1; k>MAX_SLICE is clamped to MAX_SLICE.
//     N = ceil(WIDTH/k); the remainder r = WIDTH mod k forms a short final slice.
//   - FSM IDLE -> SHIFT -> DONE -> IDLE:
//     IDLE:  in_ready=1. On in_valid&&in_ready, latch in_data, k and cfg_left; set ptr=0, acc=0; go to SHIFT.
//     SHIFT: one slice per cycle, ptr advances by k.
//       - Left stream, full slice:  acc[WIDTH-1-ptr -: k] = src[ptr +: k].
//       - Left stream, last slice (WIDTH-ptr < k): acc[0 +: WIDTH-ptr] = src[ptr +: WIDTH-ptr].
//       - Right stream: acc[ptr +: len] = src[ptr +: len].
//       - After the N-th slice go to DONE. out_data is loaded from acc.
//     DONE:  out_valid=1; out_data held stable until out_ready.
//       On out_valid&&out_ready go to IDLE. in_ready rises the following cycle (no same-cycle re-accept).
//   - Latency: accept at cycle T; out_valid rises at T+N+1. Examples: k=8 -> N=3, k=7 -> N=4, k=1 -> N=24.
//   - Changes on cfg_*/in_data while busy are ignored. Backpressure is unlimited; the result is never dropped.
//   - Reset in any state aborts the operation and discards the word; out_valid drops at that edge.
//   - acc and ptr arithmetic is sized $clog2(WIDTH+1); slice indices never exceed WIDTH-1.
// CONFIGURATION
//   STREAM_PACK_FASTPATH_EN
//     Defined:   right stream, or k >= WIDTH, skips SHIFT. The result equals in_data.
//       IDLE goes straight to DONE, so out_valid rises at T+1.
//     Undefined: every word walks all N SHIFT cycles, regardless of direction.
//     Output data is identical either way; only latency differs.
// STRUCTURE
//   - Package stream_pack_pkg:
//     - state enum {IDLE, SHIFT, DONE}
//     - localparam PTR_W
//     - function slice_count(width, k) returning ceil(width/k)
//     - function clamp_slice(k, max)
//   - Sub-module stream_slice_step: combinational. Inputs are src, acc, ptr, k, left.
//     Output is acc with one slice placed, including short-slice handling. The FSM and handshakes stay in the top module.
// TESTING
//   1. k=8, left, in 24'h060708 -> out 24'h080706; out_valid 4 cycles after accept.
//   2. k=1, left, in 24'h060708 -> out 24'h10E060; 24 SHIFT cycles.
//   3. k=7, left, in 24'h060708 -> out 24'h1038C0 (4 SHIFT cycles, 3-bit remainder slice).
//      k=7, right, in 24'h607080 -> out 24'h607080.
//   4. Hold out_ready=0 for 10 cycles after DONE -> out_data and out_valid stable; in_ready=0;
//      a new in_valid is not accepted until the handshake completes.
//   5. Assert rst_n=0 mid-SHIFT (k=1, 5th slice) -> next cycle state IDLE, out_valid=0, in_ready=1;
//      the next word (k=8, 24'hC02375) -> 24'h7523C0.
//   6. cfg_slice=0 -> behaves as k=1. cfg_slice=12 with MAX_SLICE=8 -> behaves as k=8.
//      With STREAM_PACK_FASTPATH_EN, a right stream completes at T+1.

Source files
------------

// File: rtl/stream_pack_ctrl_pkg.sv
// stream_pack_pkg: shared sizes, FSM states and slice helpers for stream_pack_ctrl
package stream_pack_pkg;
  localparam int WIDTH = 24;
  localparam int MAX_SLICE = 8;
  localparam int PTR_W = $clog2(WIDTH + 1);
  localparam int K_W = $clog2(MAX_SLICE + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic int slice_count(input int width, input int k);
    return (width + k - 1) / k;
  endfunction
  function automatic int clamp_slice(input int k, input int mx);
    return k == 0 ? 1 : (k > mx ? mx : k);
  endfunction
endpackage

// File: rtl/stream_pack_ctrl_if.sv
// stream_pack_ctrl_if: producer/consumer handshake and config bundle
interface stream_pack_ctrl_if;
  import stream_pack_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic [K_W-1:0] cfg_slice;
  logic cfg_left;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  modport master(output in_valid, in_data, cfg_slice, cfg_left, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_data, cfg_slice, cfg_left, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/stream_slice_step.sv
// stream_slice_step: places one k-bit slice of src into acc, short final slice included
module stream_slice_step import stream_pack_pkg::*; (
  input  logic [WIDTH-1:0] src_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [K_W-1:0]   k_i,
  input  logic             left_i,
  output logic [WIDTH-1:0] acc_o
);
  logic [PTR_W-1:0] rem, len, s, d;
  logic tail;
  assign rem = PTR_W'(WIDTH) - ptr_i;
  assign tail = rem < PTR_W'(k_i);
  assign len = tail ? rem : PTR_W'(k_i);
  // copy bit b of the slice; left stream mirrors slice position, the short tail lands at bit 0
  always_comb begin
    acc_o = acc_i;
    s = '0;
    d = '0;
    for (int b = 0; b < MAX_SLICE; b++) begin
      s = ptr_i + PTR_W'(b);
      d = !left_i ? s : tail ? PTR_W'(b) : PTR_W'(WIDTH - int'(ptr_i) - int'(k_i) + b);
      if (PTR_W'(b) < len) acc_o[d] = src_i[s];
    end
  end
endmodule

// File: rtl/stream_pack_ctrl.sv
// stream_pack_ctrl: slice-per-cycle stream reorder sequencer (optional STREAM_PACK_FASTPATH_EN)
module stream_pack_ctrl import stream_pack_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  stream_pack_ctrl_if.slave bus,
  output logic busy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] src_q, src_d, acc_q, acc_d, out_q, out_d, step;
  logic [PTR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, n_q, n_d;
  logic [K_W-1:0] k_q, k_d, kc;
  logic left_q, left_d, fast;
  assign kc = K_W'(clamp_slice(int'(bus.cfg_slice), MAX_SLICE));
`ifdef STREAM_PACK_FASTPATH_EN
  assign fast = !bus.cfg_left || int'(kc) >= WIDTH;
`else
  assign fast = 1'b0;
`endif
  stream_slice_step u_step (
    .src_i (src_q),
    .acc_i (acc_q),
    .ptr_i (ptr_q),
    .k_i   (k_q),
    .left_i(left_q),
    .acc_o (step)
  );
  // next state: latch word on accept, place one slice per SHIFT cycle, hold result until taken
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    acc_d = acc_q;
    out_d = out_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    n_d = n_q;
    k_d = k_q;
    left_d = left_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        src_d = bus.in_data;
        k_d = kc;
        left_d = bus.cfg_left;
        n_d = PTR_W'(slice_count(WIDTH, int'(kc)));
        ptr_d = '0;
        cnt_d = '0;
        acc_d = '0;
        state_d = fast ? DONE : SHIFT;
        out_d = fast ? bus.in_data : out_q;
      end
      SHIFT: begin
        acc_d = step;
        ptr_d = ptr_q + PTR_W'(k_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == n_q - 1'b1) begin
          state_d = DONE;
          out_d = step;
        end
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      k_q <= '0;
      left_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      acc_q <= acc_d;
      out_q <= out_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      k_q <= k_d;
      left_q <= left_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_data = out_q;
  assign busy = state_q != IDLE;
endmodule
